pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB) with forwarding and always-taken/1-bit branch prediction. It drives enable and flush/bubble controls for the PC and all four inter-stage flip-flop banks. It resolves three events: multi-cycle LSU wait, branch mispredict in EX, and load-use hazard. It keeps a memory-wait timeout watchdog and saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before forced release (>=1)
CNT_W, 32, width of performance counters
TO_W, 5, width of wait-cycle counter (must hold MEM_TIMEOUT)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_rs1_addr_decode  in  5  rs1 of instruction in ID
i_rs2_addr_decode  in  5  rs2 of instruction in ID
i_rs1_used_decode  in  1  ID instruction reads rs1
i_rs2_used_decode  in  1  ID instruction reads rs2
i_rd_addr_execute  in  5  rd of instruction in EX
i_rd_wren_execute  in  1  EX instruction writes rd
i_mem_rden_execute  in  1  EX instruction is a load
i_mispredict_execute  in  1  branch/jump resolved in EX disagrees with prediction
i_lsu_req_memory  in  1  MEM stage has a valid LSU access
i_lsu_ack  in  1  LSU completes access this cycle
i_cnt_clr  in  1  synchronous clear of both perf counters
o_en_pc  out  1  PC register enable
o_en_if_id  out  1  IF/ID enable
o_en_id_ex  out  1  ID/EX enable
o_en_ex_mem  out  1  EX/MEM enable
o_en_mem_wb  out  1  MEM/WB enable
o_flush_if_id  out  1  load NOP into IF/ID
o_flush_id_ex  out  1  load NOP into ID/EX (rd_wren=0, insn_vld=0)
o_bubble_mem_wb  out  1  force rd_wren/insn_vld low into MEM/WB
o_state  out  2  FSM state (debug)
o_mem_timeout  out  1  sticky watchdog error flag
o_stall_cnt  out  CNT_W  stall cycles, saturating
o_flush_cnt  out  CNT_W  mispredict flush events, saturating

Behaviour:
- Reset (i_reset=1, async): state=RUN, wait counter=0, o_mem_timeout=0, counters=0; all o_en_* forced 0, all flush/bubble outputs 0, o_state=RUN.
- Control outputs are combinational from state and inputs (same-cycle effect); counters and flag are registered.
- Events:
  - mem_stall = i_lsu_req_memory & ~i_lsu_ack & ~release.
  - release = state==MEM_WAIT & wait counter==MEM_TIMEOUT-1.
  - load_use = i_mem_rden_execute & i_rd_wren_execute & rd!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
- Priority: mem_stall > mispredict > load_use > normal.
- mem_stall: en_pc/if_id/id_ex/ex_mem=0; en_mem_wb=1; bubble_mem_wb=1; no flushes. A pending mispredict or load_use is held frozen in EX and is acted on in the first non-stalled cycle.
- mispredict: all enables 1; flush_if_id=1; flush_id_ex=1. load_use is ignored because the ID instruction is squashed.
- load_use: en_pc=0, en_if_id=0; en_id_ex=1 with flush_id_ex=1 (one bubble); en_ex_mem=en_mem_wb=1. The hazard clears on its own the next cycle and forwarding covers the rest.
- normal: all enables 1, all flush/bubble outputs 0.
- FSM states: RUN=0, MEM_WAIT=1.
  - RUN→MEM_WAIT when mem_stall; wait counter←1.
  - MEM_WAIT: on i_lsu_ack or ~i_lsu_req_memory → RUN, counter←0. Otherwise counter++.
  - On release: treat the cycle as acked (pipeline advances, data unspecified), set o_mem_timeout←1 (sticky until reset), → RUN.
- An ack arriving in the same cycle as the request means zero stall; the FSM stays in RUN.
- Counters:
  - o_stall_cnt +1 per cycle with mem_stall or (load_use & ~mispredict).
  - o_flush_cnt +1 per cycle with mispredict & ~mem_stall.
  - Both saturate at all-ones.
  - i_cnt_clr has priority over increment: the counter is 0 next cycle.
- Reset asserted mid-stall: immediate return to RUN with outputs as in reset. After deassert, the first cycle evaluates normally.

Decomposition:
- Package pipeline_ctrl_pkg:
  - typedef enum logic[1:0] hz_state_t {RUN, MEM_WAIT}.
  - Struct stage_ctrl_t bundling en/flush/bubble signals.
  - Localparam NOP encoding 32'h0000_0013.
- Sub-module sat_counter (CNT_W, inc, clr, async active-high reset), instantiated twice.

Test Plan:
- Load x5 in EX, ID `add x6,x5,x1` → exactly one cycle en_pc=0, en_if_id=0, flush_id_ex=1; stall_cnt 0→1.
- Load with rd=x0 matching rs1=x0 → no stall; all enables 1.
- i_mispredict_execute=1 together with load_use → flush_if_id=flush_id_ex=1, en_pc=1, flush_cnt +1, stall_cnt unchanged.
- LSU req held, ack after 3 cycles with mispredict asserted throughout → 3 cycles frozen with bubble_mem_wb=1, state=MEM_WAIT. Next cycle: flush outputs asserted, flush_cnt +1 once, stall_cnt +3.
- LSU req held, no ack, MEM_TIMEOUT=16 → release in the 16th stalled cycle, o_mem_timeout=1 and stays 1, state→RUN. Then assert i_reset → flag 0, counters 0.
- Preload stall_cnt near all-ones (CNT_W=4): 20 stall cycles → holds 4'hF. Assert i_cnt_clr during a stall → 0 next cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t   : sequencer state (RUN / MEM_WAIT), also exported as debug port
//   stage_ctrl_t : bundle of enable / flush / bubble controls for PC and stage banks
//   CTRL_*       : the fixed control patterns for each resolved event
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } hz_state_t;

    typedef struct packed {
        logic en_pc;
        logic en_if_id;
        logic en_id_ex;
        logic en_ex_mem;
        logic en_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic bubble_mem_wb;
    } stage_ctrl_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam stage_ctrl_t CTRL_RESET     = '{default: 1'b0};
    localparam stage_ctrl_t CTRL_NORMAL    = '{en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1,
                                               en_ex_mem: 1'b1, en_mem_wb: 1'b1,
                                               flush_if_id: 1'b0, flush_id_ex: 1'b0,
                                               bubble_mem_wb: 1'b0};
    // Front of the pipe frozen; MEM/WB keeps draining but receives a bubble.
    localparam stage_ctrl_t CTRL_MEM_STALL = '{en_pc: 1'b0, en_if_id: 1'b0, en_id_ex: 1'b0,
                                               en_ex_mem: 1'b0, en_mem_wb: 1'b1,
                                               flush_if_id: 1'b0, flush_id_ex: 1'b0,
                                               bubble_mem_wb: 1'b1};
    localparam stage_ctrl_t CTRL_MISPRED   = '{en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1,
                                               en_ex_mem: 1'b1, en_mem_wb: 1'b1,
                                               flush_if_id: 1'b1, flush_id_ex: 1'b1,
                                               bubble_mem_wb: 1'b0};
    // Hold PC and IF/ID, inject one bubble into ID/EX.
    localparam stage_ctrl_t CTRL_LOAD_USE  = '{en_pc: 1'b0, en_if_id: 1'b0, en_id_ex: 1'b1,
                                               en_ex_mem: 1'b1, en_mem_wb: 1'b1,
                                               flush_if_id: 1'b0, flush_id_ex: 1'b1,
                                               bubble_mem_wb: 1'b0};

    // True when a used source register matches the destination register.
    function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall / flush performance counters.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_inc          : increment this cycle (holds at all-ones)
//   i_clr          : synchronous clear, wins over i_inc
//   o_cnt          : current count
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves LSU wait (with timeout watchdog), EX mispredict and load-use hazards,
// and drives PC / IF-ID / ID-EX / EX-MEM / MEM-WB enables and flush/bubble controls.
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_rs*/i_rd*/i_mem_rden* : register usage of ID and EX instructions
//   i_mispredict_execute    : branch resolved in EX disagrees with prediction
//   i_lsu_req_memory/i_lsu_ack : MEM-stage LSU handshake
//   i_cnt_clr               : synchronous clear of both perf counters
//   o_en_* / o_flush_* / o_bubble_mem_wb : combinational pipeline controls
//   o_state, o_mem_timeout  : debug state and sticky watchdog flag
//   o_stall_cnt, o_flush_cnt: saturating performance counters
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TO_W        = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs1_addr_decode,
    input  logic [4:0]       i_rs2_addr_decode,
    input  logic             i_rs1_used_decode,
    input  logic             i_rs2_used_decode,
    input  logic [4:0]       i_rd_addr_execute,
    input  logic             i_rd_wren_execute,
    input  logic             i_mem_rden_execute,
    input  logic             i_mispredict_execute,
    input  logic             i_lsu_req_memory,
    input  logic             i_lsu_ack,
    input  logic             i_cnt_clr,
    output logic             o_en_pc,
    output logic             o_en_if_id,
    output logic             o_en_id_ex,
    output logic             o_en_ex_mem,
    output logic             o_en_mem_wb,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_bubble_mem_wb,
    output logic [1:0]       o_state,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    hz_state_t       state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            timeout_q, timeout_d;

    logic        release_w;
    logic        mem_stall;
    logic        load_use;
    logic        stall_inc;
    logic        flush_inc;
    stage_ctrl_t ctrl;

    // >= rather than == so that MEM_TIMEOUT=1 still releases (counter enters at 1).
    assign release_w = (state_q == MEM_WAIT) && (wait_q >= WAIT_LAST);
    assign mem_stall = i_lsu_req_memory && !i_lsu_ack && !release_w;
    assign load_use  = i_mem_rden_execute && i_rd_wren_execute && (i_rd_addr_execute != 5'd0)
                    && (src_hit(i_rs1_used_decode, i_rs1_addr_decode, i_rd_addr_execute)
                     || src_hit(i_rs2_used_decode, i_rs2_addr_decode, i_rd_addr_execute));

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (i_lsu_ack || !i_lsu_req_memory) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (release_w) begin
                    // Forced release: pipeline advances as if acked.
                    state_d   = RUN;
                    wait_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Output logic: event priority mem_stall > mispredict > load_use > normal
    always_comb begin
        ctrl = CTRL_NORMAL;
        if (i_reset) begin
            ctrl = CTRL_RESET;
        end else if (mem_stall) begin
            ctrl = CTRL_MEM_STALL;
        end else if (i_mispredict_execute) begin
            ctrl = CTRL_MISPRED;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    assign o_en_pc         = ctrl.en_pc;
    assign o_en_if_id      = ctrl.en_if_id;
    assign o_en_id_ex      = ctrl.en_id_ex;
    assign o_en_ex_mem     = ctrl.en_ex_mem;
    assign o_en_mem_wb     = ctrl.en_mem_wb;
    assign o_flush_if_id   = ctrl.flush_if_id;
    assign o_flush_id_ex   = ctrl.flush_id_ex;
    assign o_bubble_mem_wb = ctrl.bubble_mem_wb;
    assign o_state         = state_q;
    assign o_mem_timeout   = timeout_q;

    // A load-use hazard under a mispredict is squashed and not counted.
    assign stall_inc = mem_stall || (load_use && !i_mispredict_execute);
    assign flush_inc = i_mispredict_execute && !mem_stall;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (stall_inc),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (flush_inc),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_flush_cnt)
    );

endmodule
